// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Instruction fetch stage. Issues sequential word fetches on the instruction
//   bus, starting at BOOT_ADDR or at a branch target. Several requests may be
//   outstanding at once. Returned words are buffered in an in-order FIFO
//   together with their PC and handed to decode. A branch flushes the FIFO,
//   and responses to requests issued before the branch are dropped.
//
// Ports
//   clk, rst          clock (posedge) and asynchronous active-high reset
//   fetch_en_i        permits new bus requests while high
//   branch_i          one-cycle redirect pulse, target in branch_addr_i
//   inst_req_o/addr_o bus request and its word address
//   inst_gnt_i        request accepted this cycle
//   inst_rvalid_i     in-order response, data in inst_rdata_i
//   instr_valid_o     FIFO head valid; instr_rdata_o / instr_addr_o = word / PC
//   instr_ready_i     decode accepts the FIFO head
//   dbg_state         current FSM state (0 IDLE, 1 REQ, 2 FLUSH_HOLD)
//
// Handshakes
//   Bus side: once inst_req_o rises, inst_req_o and inst_addr_o hold until the
//   cycle inst_gnt_i is high, which completes the request. One response
//   (inst_rvalid_i) returns per granted request, in order, at least one cycle
//   after its grant. Decode side: a transfer happens in every cycle where
//   instr_valid_o and instr_ready_i are both high, unless branch_i is high in
//   that cycle (the flush wins and nothing is transferred).

module inst_fetch_unit #(
    parameter int unsigned       BUS_AW          = 32,
    parameter int unsigned       BUS_DW          = 32,
    parameter int unsigned       FIFO_DEPTH      = 4,
    parameter int unsigned       MAX_OUTSTANDING = 2,
    parameter logic [BUS_AW-1:0] BOOT_ADDR       = BUS_AW'(32'h0000_0080)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en_i,
    input  logic              branch_i,
    input  logic [BUS_AW-1:0] branch_addr_i,
    output logic              inst_req_o,
    output logic [BUS_AW-1:0] inst_addr_o,
    input  logic              inst_gnt_i,
    input  logic              inst_rvalid_i,
    input  logic [BUS_DW-1:0] inst_rdata_i,
    output logic              instr_valid_o,
    output logic [BUS_DW-1:0] instr_rdata_o,
    output logic [BUS_AW-1:0] instr_addr_o,
    input  logic              instr_ready_i,
    output logic [1:0]        dbg_state
);

    localparam int unsigned       PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned       CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [BUS_AW-1:0] ADDR_STEP  = BUS_AW'(4);
    localparam logic [BUS_AW-1:0] ALIGN_MASK = ~BUS_AW'(3);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_REQ        = 2'd1,
        S_FLUSH_HOLD = 2'd2
    } state_e;

    state_e            state_q;
    logic [BUS_AW-1:0] saved_q;     // branch target parked while a stale request waits for grant
    logic [BUS_AW-1:0] pc_q;        // PC of the next accepted response
    logic [CNT_W-1:0]  out_q;       // granted, response not yet returned
    logic [CNT_W-1:0]  disc_q;      // responses still to be dropped
    logic [CNT_W-1:0]  cnt_q;       // FIFO occupancy
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [BUS_DW-1:0] fifo_data_q [FIFO_DEPTH];
    logic [BUS_AW-1:0] fifo_pc_q   [FIFO_DEPTH];

    logic              fire_gnt;
    logic              push;
    logic              pop;
    logic              issue_d;
    logic [CNT_W-1:0]  out_d;
    logic [CNT_W-1:0]  disc_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W:0]    occ_d;
    logic [BUS_AW-1:0] target;

    assign target        = branch_addr_i & ALIGN_MASK;
    assign instr_valid_o = (cnt_q != '0);
    assign instr_rdata_o = fifo_data_q[rd_ptr_q];
    assign instr_addr_o  = fifo_pc_q[rd_ptr_q];
    assign dbg_state     = state_q;

    // Next-cycle bookkeeping. The issue decision uses the counts as they will
    // be after this cycle's grant, response, push and pop, so a grant that
    // uses up the last credit stops the request stream immediately.
    always_comb begin
        fire_gnt = inst_req_o & inst_gnt_i;
        pop      = instr_valid_o & instr_ready_i & ~branch_i;
        push     = inst_rvalid_i & ~branch_i & (disc_q == '0);
        out_d    = out_q + CNT_W'(fire_gnt) - CNT_W'(inst_rvalid_i);

        if (branch_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end

        occ_d   = {1'b0, cnt_d} + {1'b0, out_d};
        issue_d = fetch_en_i
                & (occ_d < (CNT_W+1)'(FIFO_DEPTH))
                & (out_d < CNT_W'(MAX_OUTSTANDING));

        // On a branch every request still in flight after this cycle is stale.
        // A request parked in FLUSH_HOLD becomes stale when it is granted.
        if (branch_i) begin
            disc_d = out_d;
        end else begin
            disc_d = disc_q;
            if (inst_rvalid_i && (disc_q != '0)) begin
                disc_d = disc_d - CNT_W'(1);
            end
            if ((state_q == S_FLUSH_HOLD) && fire_gnt) begin
                disc_d = disc_d + CNT_W'(1);
            end
        end
    end

    // Request FSM: owns inst_req_o, inst_addr_o and the parked branch target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            inst_req_o  <= 1'b0;
            inst_addr_o <= BOOT_ADDR;
            saved_q     <= BOOT_ADDR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (branch_i) begin
                        inst_addr_o <= target;
                    end
                    if (issue_d) begin
                        state_q    <= S_REQ;
                        inst_req_o <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (fire_gnt) begin
                        inst_addr_o <= branch_i ? target : (inst_addr_o + ADDR_STEP);
                        state_q     <= issue_d ? S_REQ : S_IDLE;
                        inst_req_o  <= issue_d;
                    end else if (branch_i) begin
                        // The raised request cannot be withdrawn: hold it and
                        // redirect once it has been granted.
                        saved_q <= target;
                        state_q <= S_FLUSH_HOLD;
                    end
                end
                S_FLUSH_HOLD: begin
                    if (branch_i) begin
                        saved_q <= target;
                    end
                    if (fire_gnt) begin
                        inst_addr_o <= branch_i ? target : saved_q;
                        state_q     <= issue_d ? S_REQ : S_IDLE;
                        inst_req_o  <= issue_d;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    inst_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Counters, PC tracking and the instruction FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= BOOT_ADDR;
            out_q    <= '0;
            disc_q   <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            out_q  <= out_d;
            disc_q <= disc_d;
            cnt_q  <= cnt_d;
            if (branch_i) begin
                pc_q     <= target;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_data_q[wr_ptr_q] <= inst_rdata_i;
                    fifo_pc_q[wr_ptr_q]   <= pc_q;
                    wr_ptr_q              <= wr_ptr_q + 1'b1;
                    pc_q                  <= pc_q + ADDR_STEP;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    // Credit accounting must make these impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (cnt_q == CNT_W'(FIFO_DEPTH))));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(inst_rvalid_i && (out_q == '0)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: a bus responder with a grant budget and a
// response gate, directed scenarios that push expected bus addresses and
// expected {pc, word} pairs, and a monitor that pops and compares them.

module tb_inst_fetch_unit;

    localparam int W = 64;

    logic        clk;
    logic        rst;
    logic        fetch_en_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_gnt_i;
    logic        inst_rvalid_i;
    logic [31:0] inst_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        instr_ready_i;
    logic [1:0]  dbg_state;

    inst_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en_i    (fetch_en_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .inst_req_o    (inst_req_o),
        .inst_addr_o   (inst_addr_o),
        .inst_gnt_i    (inst_gnt_i),
        .inst_rvalid_i (inst_rvalid_i),
        .inst_rdata_i  (inst_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_addr_o  (instr_addr_o),
        .instr_ready_i (instr_ready_i),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0]  exp_q[$];       // {pc, word} expected at decode
    logic [31:0]   exp_addr_q[$];  // expected granted bus addresses
    logic [31:0]   rsp_q[$];       // granted addresses awaiting response
    int            pass_cnt;
    int            total_cnt;
    int            gnt_budget;
    bit            rsp_en;
    bit            mon_en;
    int            gnt_count;
    int            cyc;
    int            first_gnt_cyc;
    int            last_gnt_cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endfunction

    task automatic expect_seq(input logic [31:0] start, input int n, input bit grants, input bit insts);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            if (grants) exp_addr_q.push_back(a);
            if (insts) exp_q.push_back({a, mem_word(a)});
            a = a + 32'd4;
        end
    endtask

    task automatic reset_checks(input string name);
        check({name, "_req"}, 64'(inst_req_o), 64'd0);
        check({name, "_addr"}, 64'(inst_addr_o), 64'h80);
        check({name, "_valid"}, 64'(instr_valid_o), 64'd0);
        check({name, "_rdata"}, 64'(instr_rdata_o), 64'd0);
        check({name, "_pc"}, 64'(instr_addr_o), 64'd0);
        check({name, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        fetch_en_i    = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        instr_ready_i = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        reset_checks(name);
        gnt_budget = 0;
        rsp_en     = 1'b1;
        mon_en     = 1'b1;
        gnt_count  = 0;
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && k < 200) begin
            @(negedge clk);
            #3;
            k++;
        end
        total_cnt++;
        if (exp_q.size() == 0 && exp_addr_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s_drain: %0d grants and %0d instructions outstanding after 200 cycles, required 0",
                     name, exp_addr_q.size(), exp_q.size());
            exp_q.delete();
            exp_addr_q.delete();
        end
    endtask

    // ---------------- bus responder (driver) ----------------
    initial begin : responder
        logic [31:0] a;
        inst_gnt_i    = 1'b0;
        inst_rvalid_i = 1'b0;
        inst_rdata_i  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                rsp_q.delete();
                inst_gnt_i    = 1'b0;
                inst_rvalid_i = 1'b0;
                inst_rdata_i  = '0;
            end else begin
                if (rsp_en && rsp_q.size() > 0) begin
                    a             = rsp_q.pop_front();
                    inst_rvalid_i = 1'b1;
                    inst_rdata_i  = mem_word(a);
                end else begin
                    inst_rvalid_i = 1'b0;
                    inst_rdata_i  = '0;
                end
                inst_gnt_i = (gnt_budget > 0);
                if (inst_req_o && inst_gnt_i) begin
                    rsp_q.push_back(inst_addr_o);
                    gnt_budget--;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [31:0]  ea;
        logic [W-1:0] ei;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!rst && mon_en) begin
                if (inst_req_o && inst_gnt_i) begin
                    if (gnt_count == 0) first_gnt_cyc = cyc;
                    last_gnt_cyc = cyc;
                    gnt_count++;
                    if (exp_addr_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL grant_addr: unexpected grant of 0x%08h, no grant required", inst_addr_o);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("grant_addr", 64'(inst_addr_o), 64'(ea));
                    end
                end
                if (instr_valid_o && instr_ready_i && !branch_i) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL decode: unexpected instruction pc 0x%08h word 0x%08h, none required",
                                 instr_addr_o, instr_rdata_o);
                    end else begin
                        ei = exp_q.pop_front();
                        check("decode_pc_word", {instr_addr_o, instr_rdata_o}, ei);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #400000;
        total_cnt++;
        $display("FAIL watchdog: time limit reached, required test completion");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin : stimulus
        logic [31:0] wrap_vec [4];
        pass_cnt      = 0;
        total_cnt     = 0;
        cyc           = 0;
        gnt_budget    = 0;
        gnt_count     = 0;
        first_gnt_cyc = 0;
        last_gnt_cyc  = 0;
        rsp_en        = 1'b1;
        mon_en        = 1'b0;
        rst           = 1'b0;
        fetch_en_i    = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        instr_ready_i = 1'b0;

        // 1: streaming, one request per cycle from BOOT_ADDR
        do_reset("t1_reset");
        instr_ready_i = 1'b1;
        expect_seq(32'h80, 8, 1'b1, 1'b1);
        gnt_budget = 8;
        fetch_en_i = 1'b1;
        drain("t1");
        check("t1_gnt_count", 64'(gnt_count), 64'd8);
        check("t1_back_to_back", 64'(last_gnt_cyc - first_gnt_cyc), 64'd7);

        // 2: decode stalled, fetch stops once the FIFO is fully committed
        do_reset("t2_reset");
        expect_seq(32'h80, 4, 1'b1, 1'b0);
        gnt_budget = 4;
        fetch_en_i = 1'b1;
        repeat (12) @(negedge clk);
        #3;
        check("t2_gnt_count", 64'(gnt_count), 64'd4);
        check("t2_req_dropped", 64'(inst_req_o), 64'd0);
        check("t2_head_valid", 64'(instr_valid_o), 64'd1);
        check("t2_head_pc", 64'(instr_addr_o), 64'h80);
        check("t2_head_word", 64'(instr_rdata_o), 64'h C0DE_5ADA);
        expect_seq(32'h80, 8, 1'b0, 1'b1);
        expect_seq(32'h90, 4, 1'b1, 1'b0);
        gnt_budget = 4;
        @(negedge clk);
        instr_ready_i = 1'b1;
        drain("t2");

        // 3: grant withheld on 0x84, request must hold steady
        do_reset("t3_reset");
        instr_ready_i = 1'b1;
        expect_seq(32'h80, 1, 1'b1, 1'b1);
        gnt_budget = 1;
        fetch_en_i = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #3;
            check("t3_req_held", 64'(inst_req_o), 64'd1);
            check("t3_addr_held", 64'(inst_addr_o), 64'h84);
        end
        expect_seq(32'h84, 3, 1'b1, 1'b1);
        gnt_budget = 3;
        drain("t3");

        // 4: branch to 0x203 with two requests in flight
        do_reset("t4_reset");
        instr_ready_i = 1'b1;
        rsp_en = 1'b0;
        expect_seq(32'h80, 2, 1'b1, 1'b0);
        gnt_budget = 2;
        fetch_en_i = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        check("t4_req_at_max_outstanding", 64'(inst_req_o), 64'd0);
        check("t4_next_addr", 64'(inst_addr_o), 64'h88);
        @(negedge clk);
        branch_i      = 1'b1;
        branch_addr_i = 32'h203;
        expect_seq(32'h200, 3, 1'b1, 1'b1);
        gnt_budget = 3;
        @(negedge clk);
        branch_i = 1'b0;
        rsp_en   = 1'b1;
        drain("t4");

        // 5: branch while the request to 0x90 is still ungranted
        do_reset("t5_reset");
        instr_ready_i = 1'b1;
        expect_seq(32'h80, 4, 1'b1, 1'b1);
        gnt_budget = 4;
        fetch_en_i = 1'b1;
        drain("t5_pre");
        @(negedge clk);
        #3;
        check("t5_req_pending", 64'(inst_req_o), 64'd1);
        check("t5_addr_pending", 64'(inst_addr_o), 64'h90);
        @(negedge clk);
        branch_i      = 1'b1;
        branch_addr_i = 32'h400;
        @(negedge clk);
        branch_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #3;
            check("t5_hold_req", 64'(inst_req_o), 64'd1);
            check("t5_hold_addr", 64'(inst_addr_o), 64'h90);
            check("t5_hold_state", 64'(dbg_state), 64'd2);
        end
        exp_addr_q.push_back(32'h90);
        expect_seq(32'h400, 3, 1'b1, 1'b1);
        gnt_budget = 4;
        drain("t5");

        // 6a: address wrap from 0xFFFF_FFFC
        do_reset("t6_reset");
        instr_ready_i = 1'b1;
        @(negedge clk);
        branch_i      = 1'b1;
        branch_addr_i = 32'hFFFF_FFFC;
        @(negedge clk);
        branch_i = 1'b0;
        wrap_vec[0] = 32'hFFFF_FFFC;
        wrap_vec[1] = 32'h0000_0000;
        wrap_vec[2] = 32'h0000_0004;
        wrap_vec[3] = 32'h0000_0008;
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(wrap_vec[i]);
            exp_q.push_back({wrap_vec[i], mem_word(wrap_vec[i])});
        end
        gnt_budget = 4;
        fetch_en_i = 1'b1;
        drain("t6_wrap");

        // 6b: asynchronous reset in the middle of a burst, then restart
        do_reset("t6b_reset");
        instr_ready_i = 1'b1;
        mon_en     = 1'b0;
        gnt_budget = 1000;
        fetch_en_i = 1'b1;
        repeat (5) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        reset_checks("t6b_async");
        gnt_budget = 0;
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        expect_seq(32'h80, 4, 1'b1, 1'b1);
        gnt_budget = 4;
        drain("t6b_restart");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Core-side instruction fetch stage that drives the instruction bus (`inst_req_o`/`inst_addr_o`) and consumes `inst_gnt_i`, `inst_rvalid_i` and `inst_rdata_i`.
- Issues sequential word fetches from `BOOT_ADDR` or from a branch target, with multiple requests outstanding.
- Buffers returned instructions in an in-order FIFO and presents them to decode on a valid/ready handshake.
- Branches flush the FIFO and discard stale responses.

Parameters:
- BUS_AW, 32, instruction address width (`bus_params_pkg::BUS_AW`)
- BUS_DW, 32, instruction data width (`bus_params_pkg::BUS_DW`)
- FIFO_DEPTH, 4, instruction buffer entries (power of 2, ≥2)
- MAX_OUTSTANDING, 2, maximum granted-but-not-returned requests (1..FIFO_DEPTH)
- BOOT_ADDR, 32'h0000_0080, first fetch address after reset (word aligned)

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- fetch_en_i  input  1  permits new requests while high
- branch_i  input  1  one-cycle redirect pulse
- branch_addr_i  input  BUS_AW  redirect target (bits [1:0] ignored, forced 0)
- inst_req_o  output  1  bus request
- inst_addr_o  output  BUS_AW  bus request address
- inst_gnt_i  input  1  request accepted this cycle
- inst_rvalid_i  input  1  response data valid
- inst_rdata_i  input  BUS_DW  response instruction word
- instr_valid_o  output  1  FIFO head valid to decode
- instr_rdata_o  output  BUS_DW  FIFO head instruction
- instr_addr_o  output  BUS_AW  PC of FIFO head
- instr_ready_i  input  1  decode accepts head

Behaviour:
- **Clock and reset:** one clock (`clk`); reset `rst` is asynchronous and active-high. While `rst` is high, everything clears immediately:
  - `inst_req_o`=0, `inst_addr_o`=BOOT_ADDR, `instr_valid_o`=0, `instr_rdata_o`=0, `instr_addr_o`=0.
  - FIFO, outstanding counter and discard counter = 0; state = IDLE.
  - The memory side shares the same reset, so no pre-reset response arrives afterwards.
- **Bus rules:**
  - Once raised, `inst_req_o` and `inst_addr_o` stay stable until the cycle `inst_gnt_i`=1; a request is never withdrawn.
  - Responses return in order, at least one cycle after their grant.
- **Credit:** `credit` = FIFO_DEPTH − fifo_count − outstanding. A new request may be raised only when `fetch_en_i`=1, `credit`>0 and outstanding<MAX_OUTSTANDING.
- **States:**
  - IDLE: `inst_req_o`=0. Moves to REQ when the issue condition holds.
  - REQ: `inst_req_o`=1.
    - On grant: outstanding++ and `inst_addr_o` += 4, wrapping modulo 2^BUS_AW.
    - If the issue condition still holds after counting this grant, stay in REQ (back-to-back requests, one per cycle); otherwise go to IDLE.
  - FLUSH_HOLD: entered when `branch_i` arrives while in REQ without a same-cycle grant.
    - Keeps `inst_req_o`/`inst_addr_o` held until grant.
    - That request is counted both outstanding and to-discard.
    - On its grant, `inst_addr_o` loads the saved branch target; then go to IDLE/REQ by the issue condition.
- **Branch handling (`branch_i`=1):**
  - FIFO emptied the same cycle: `instr_valid_o`=0 from the next cycle.
  - Discard counter ← current outstanding, including a request granted in this same cycle.
  - In IDLE or REQ-with-grant: `inst_addr_o` ← `branch_addr_i` & ~3 next cycle.
  - A second branch during FLUSH_HOLD overwrites the saved target.
- **Responses:** on `inst_rvalid_i`, outstanding--.
  - If discard>0: discard--, data dropped.
  - Otherwise: push {`inst_rdata_i`, pc}, where pc is a pc-tracking register advanced by 4 per accepted response and reloaded on branch.
  - Credit accounting guarantees no push into a full FIFO; overflow is a design error, covered by an assertion.
- **Pop:** occurs when `instr_valid_o`&&`instr_ready_i`. Push and pop in the same cycle are both performed, count unchanged. A response that arrives into an empty FIFO becomes visible on `instr_valid_o` in the following cycle (1-cycle latency).
- **Simultaneous events:**
  - `branch_i` takes priority over a pop that cycle.
  - A response in the same cycle as `branch_i` is discarded.
  - A grant and `rvalid` in the same cycle leave outstanding unchanged.
- **`fetch_en_i`=0:** blocks only new requests. An already-raised request stays held until grant; responses continue to be accepted.

Test Plan:
1. Reset release, `fetch_en_i`=1, gnt tied 1, rvalid 1 cycle after gnt, `instr_ready_i`=1 → addresses 0x80, 0x84, 0x88… one per cycle; `instr_addr_o` sequence matches; data matches memory model.
2. `instr_ready_i`=0 with FIFO_DEPTH=4 → exactly 4 requests issued, `inst_req_o` drops, FIFO holds 0x80..0x8C. Raising ready resumes fetch at 0x90.
3. gnt withheld 3 cycles on request to 0x84 → `inst_req_o`=1 and `inst_addr_o`=0x84 stable all 3 cycles; no new address before grant.
4. `branch_i` with `branch_addr_i`=0x203 while 2 requests are outstanding → both responses dropped; next request address 0x200; first `instr_addr_o` after branch = 0x200.
5. `branch_i` during ungranted request to 0x90, target 0x400 → 0x90 held until gnt, its data discarded, next request 0x400.
6. Start at 0xFFFF_FFFC via branch → next address wraps to 0x0000_0000; async `rst` asserted mid-burst → all outputs at reset values immediately, restart at 0x80.
